// File: rtl/commit_progress_monitor.sv
// ---------------------------------------------------------------------------
// commit_progress_monitor
//
// Watches an N-wide retire bus and keeps cumulative commit and run-cycle
// counters. Every WINDOW commits it emits a one-cycle progress report with
// cumulative commits, cycles spent in the window and cumulative cycles. It
// also decides how the run ended (halt, error, global timeout or stall) and
// latches that outcome into a sticky status for a bench or FPGA host to poll.
//
// Optional feature macro: COMMIT_MON_STALL_EN
//   defined   -> stall counter and STALL termination (status 4) compiled in
//   undefined -> no stall counter; STALL_LIMIT has no effect
//
// Ports:
//   clk                    clock
//   rst_n                  asynchronous active-low reset
//   commit_valid_i         per-channel retire strobes (any pattern legal)
//   halt_in_i              program-requested halt
//   error_in_i             checker error
//   report_valid_o         one-cycle pulse when a window boundary is crossed
//   report_commits_o       cumulative commits at the last report
//   report_win_cycles_o    cycles covered by the last report's window
//   report_total_cycles_o  cumulative run cycles at the last report
//   total_commits_o        live cumulative commit count
//   total_cycles_o         live cumulative run-cycle count
//   done_o                 sticky run-terminated flag
//   status_o               0 RUN, 1 HALT, 2 ERROR, 3 TIMEOUT, 4 STALL
// ---------------------------------------------------------------------------
module commit_progress_monitor #(
  parameter int unsigned NUM_CHANNELS   = 2,
  parameter int unsigned CNT_W          = 64,
  parameter int unsigned WINDOW         = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned STALL_LIMIT    = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CHANNELS-1:0] commit_valid_i,
  input  logic                    halt_in_i,
  input  logic                    error_in_i,
  output logic                    report_valid_o,
  output logic [CNT_W-1:0]        report_commits_o,
  output logic [CNT_W-1:0]        report_win_cycles_o,
  output logic [CNT_W-1:0]        report_total_cycles_o,
  output logic [CNT_W-1:0]        total_commits_o,
  output logic [CNT_W-1:0]        total_cycles_o,
  output logic                    done_o,
  output logic [2:0]              status_o
);

  localparam int unsigned PC_W  = $clog2(NUM_CHANNELS + 1);
  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  // One extra bit so remainder + popcount never overflows before the compare.
  localparam int unsigned SUM_W = WIN_W + PC_W + 1;
  localparam logic [SUM_W-1:0] WIN_LIM = SUM_W'(WINDOW);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES);

  // Configuration sanity: the one-crossing-per-cycle argument needs
  // WINDOW >= NUM_CHANNELS, and a zero stall limit would be meaningless.
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8 || WINDOW < NUM_CHANNELS ||
      STALL_LIMIT == 0) begin : g_bad_cfg
    $error("commit_progress_monitor: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_HALT    = 3'd1,
    ST_ERROR   = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_STALL   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  total_commits_q, total_commits_d;
  logic [CNT_W-1:0]  total_cycles_q, total_cycles_d;
  logic [CNT_W-1:0]  win_cyc_q, win_cyc_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic              report_valid_q, report_valid_d;
  logic [CNT_W-1:0]  report_commits_q, report_commits_d;
  logic [CNT_W-1:0]  report_win_cycles_q, report_win_cycles_d;
  logic [CNT_W-1:0]  report_total_cycles_q, report_total_cycles_d;

  logic [PC_W-1:0]   pc;
  logic [SUM_W-1:0]  win_sum;
  logic              crossing;
  logic              timeout_hit;
  logic              stall_hit;

  always_comb begin
    pc = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      pc = pc + PC_W'(commit_valid_i[i]);
    end
  end

  assign win_sum     = SUM_W'(win_cnt_q) + SUM_W'(pc);
  assign crossing    = (win_sum >= WIN_LIM);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((total_cycles_q + CNT_W'(1)) == TO_LIM);

`ifdef COMMIT_MON_STALL_EN
  localparam int unsigned STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [STALL_W:0] STALL_LIM = (STALL_W + 1)'(STALL_LIMIT);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  assign stall_hit = (pc == '0) &&
                     (({1'b0, stall_cnt_q} + (STALL_W + 1)'(1)) == STALL_LIM);

  // Consecutive commit-free cycles; only advances while the run is live.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_RUN) begin
      stall_cnt_d = (pc != '0) ? '0 : stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end
`else
  assign stall_hit = 1'b0;
`endif

  // Next-state and counter update. Terminal states hold everything.
  always_comb begin
    state_d               = state_q;
    total_commits_d       = total_commits_q;
    total_cycles_d        = total_cycles_q;
    win_cyc_d             = win_cyc_q;
    win_cnt_d             = win_cnt_q;
    report_valid_d        = 1'b0;
    report_commits_d      = report_commits_q;
    report_win_cycles_d   = report_win_cycles_q;
    report_total_cycles_d = report_total_cycles_q;

    if (state_q == ST_RUN) begin
      total_commits_d = total_commits_q + CNT_W'(pc);
      total_cycles_d  = total_cycles_q + CNT_W'(1);

      if (crossing) begin
        // Overshoot is carried into the next window to avoid drift.
        win_cnt_d             = WIN_W'(win_sum - WIN_LIM);
        win_cyc_d             = '0;
        report_valid_d        = 1'b1;
        report_commits_d      = total_commits_d;
        report_win_cycles_d   = win_cyc_q + CNT_W'(1);
        report_total_cycles_d = total_cycles_d;
      end else begin
        win_cnt_d = WIN_W'(win_sum);
        win_cyc_d = win_cyc_q + CNT_W'(1);
      end

      if (error_in_i)       state_d = ST_ERROR;
      else if (halt_in_i)   state_d = ST_HALT;
      else if (timeout_hit) state_d = ST_TIMEOUT;
      else if (stall_hit)   state_d = ST_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q               <= ST_RUN;
      total_commits_q       <= '0;
      total_cycles_q        <= '0;
      win_cyc_q             <= '0;
      win_cnt_q             <= '0;
      report_valid_q        <= 1'b0;
      report_commits_q      <= '0;
      report_win_cycles_q   <= '0;
      report_total_cycles_q <= '0;
    end else begin
      state_q               <= state_d;
      total_commits_q       <= total_commits_d;
      total_cycles_q        <= total_cycles_d;
      win_cyc_q             <= win_cyc_d;
      win_cnt_q             <= win_cnt_d;
      report_valid_q        <= report_valid_d;
      report_commits_q      <= report_commits_d;
      report_win_cycles_q   <= report_win_cycles_d;
      report_total_cycles_q <= report_total_cycles_d;
    end
  end

  assign report_valid_o        = report_valid_q;
  assign report_commits_o      = report_commits_q;
  assign report_win_cycles_o   = report_win_cycles_q;
  assign report_total_cycles_o = report_total_cycles_q;
  assign total_commits_o       = total_commits_q;
  assign total_cycles_o        = total_cycles_q;
  assign done_o                = (state_q != ST_RUN);
  assign status_o              = state_q;

endmodule

// File: tb/tb_commit_progress_monitor.sv
// ---------------------------------------------------------------------------
// tb_commit_progress_monitor
//
// Two monitor instances share one clock and input set: a "big" one
// (WINDOW=1000, timeout disabled) and a "small" one (WINDOW=3,
// TIMEOUT_CYCLES=20, STALL_LIMIT=8). The idle instance is held in reset.
// A behavioural model predicts counters and status, and pushes each expected
// report into a queue that is popped whenever the DUT raises report_valid.
// ---------------------------------------------------------------------------
module tb_commit_progress_monitor;

  localparam int unsigned BIG_WIN     = 1000;
  localparam int unsigned SMALL_WIN   = 3;
  localparam int unsigned SMALL_TO    = 20;
  localparam int unsigned SMALL_STALL = 8;
  localparam int unsigned BIG_STALL   = 100000;

  typedef struct {
    logic [63:0] commits;
    logic [63:0] winCycles;
    logic [63:0] totalCycles;
  } rep_t;

  logic        clk = 1'b0;
  logic        rstBig = 1'b0;
  logic        rstSmall = 1'b0;
  logic [1:0]  cv = 2'b00;
  logic        halt = 1'b0;
  logic        err = 1'b0;
  bit          sel = 1'b0;

  logic        bRepValid, sRepValid;
  logic [63:0] bRepCommits, sRepCommits;
  logic [63:0] bRepWin, sRepWin;
  logic [63:0] bRepTotal, sRepTotal;
  logic [63:0] bCommits, sCommits;
  logic [63:0] bCycles, sCycles;
  logic        bDone, sDone;
  logic [2:0]  bStatus, sStatus;

  logic        obsRepValid;
  logic [63:0] obsRepCommits, obsRepWin, obsRepTotal, obsCommits, obsCycles;
  logic        obsDone;
  logic [2:0]  obsStatus;

  int vectors = 0;
  int miscompares = 0;
  int nReports = 0;

  rep_t        sbQ[$];
  logic [63:0] mCommits, mCycles, mLastRep, mStallCnt;
  logic [2:0]  mStatus;
  logic        expRepValid;
  rep_t        expRep;

  always #5 clk = ~clk;

  commit_progress_monitor #(
    .NUM_CHANNELS(2), .CNT_W(64), .WINDOW(BIG_WIN),
    .TIMEOUT_CYCLES(0), .STALL_LIMIT(BIG_STALL)
  ) u_big (
    .clk(clk), .rst_n(rstBig), .commit_valid_i(cv),
    .halt_in_i(halt), .error_in_i(err),
    .report_valid_o(bRepValid), .report_commits_o(bRepCommits),
    .report_win_cycles_o(bRepWin), .report_total_cycles_o(bRepTotal),
    .total_commits_o(bCommits), .total_cycles_o(bCycles),
    .done_o(bDone), .status_o(bStatus)
  );

  commit_progress_monitor #(
    .NUM_CHANNELS(2), .CNT_W(64), .WINDOW(SMALL_WIN),
    .TIMEOUT_CYCLES(SMALL_TO), .STALL_LIMIT(SMALL_STALL)
  ) u_small (
    .clk(clk), .rst_n(rstSmall), .commit_valid_i(cv),
    .halt_in_i(halt), .error_in_i(err),
    .report_valid_o(sRepValid), .report_commits_o(sRepCommits),
    .report_win_cycles_o(sRepWin), .report_total_cycles_o(sRepTotal),
    .total_commits_o(sCommits), .total_cycles_o(sCycles),
    .done_o(sDone), .status_o(sStatus)
  );

  // Observe whichever instance is currently under test.
  assign obsRepValid   = sel ? sRepValid   : bRepValid;
  assign obsRepCommits = sel ? sRepCommits : bRepCommits;
  assign obsRepWin     = sel ? sRepWin     : bRepWin;
  assign obsRepTotal   = sel ? sRepTotal   : bRepTotal;
  assign obsCommits    = sel ? sCommits    : bCommits;
  assign obsCycles     = sel ? sCycles     : bCycles;
  assign obsDone       = sel ? sDone       : bDone;
  assign obsStatus     = sel ? sStatus     : bStatus;

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mCommits    = '0;
    mCycles     = '0;
    mLastRep    = '0;
    mStallCnt   = '0;
    mStatus     = 3'd0;
    expRepValid = 1'b0;
    expRep      = '{commits: '0, winCycles: '0, totalCycles: '0};
    sbQ.delete();
  endtask

  // Predicts the state the DUT shows after the next clock edge.
  task automatic modelStep(input logic [1:0] c, input logic h, input logic e);
    logic [63:0] pcv, oldCommits, win, to, stallLim;
    logic [2:0]  term;
    rep_t        r;
    expRepValid = 1'b0;
    if (mStatus != 3'd0) return;
    win      = sel ? 64'(SMALL_WIN) : 64'(BIG_WIN);
    to       = sel ? 64'(SMALL_TO) : 64'd0;
    stallLim = sel ? 64'(SMALL_STALL) : 64'(BIG_STALL);
    pcv      = 64'($countones(c));
    term     = 3'd0;
    if (e) term = 3'd2;
    else if (h) term = 3'd1;
    else if (to != 0 && mCycles + 1 == to) term = 3'd3;
`ifdef COMMIT_MON_STALL_EN
    else if (pcv == 0 && mStallCnt + 1 == stallLim) term = 3'd4;
`endif
    oldCommits = mCommits;
    mCommits   = mCommits + pcv;
    mCycles    = mCycles + 1;
    mStallCnt  = (pcv != 0) ? 64'd0 : mStallCnt + 1;
    if ((mCommits / win) != (oldCommits / win)) begin
      r.commits     = mCommits;
      r.winCycles   = mCycles - mLastRep;
      r.totalCycles = mCycles;
      sbQ.push_back(r);
      expRep      = r;
      expRepValid = 1'b1;
      mLastRep    = mCycles;
    end
    mStatus = term;
  endtask

  task automatic checkAll();
    rep_t r;
    checkOutput("totalCommits", obsCommits, mCommits);
    checkOutput("totalCycles", obsCycles, mCycles);
    checkOutput("done", 64'(obsDone), 64'(mStatus != 3'd0));
    checkOutput("status", 64'(obsStatus), 64'(mStatus));
    checkOutput("reportValid", 64'(obsRepValid), 64'(expRepValid));
    checkOutput("reportCommitsHold", obsRepCommits, expRep.commits);
    checkOutput("reportWinHold", obsRepWin, expRep.winCycles);
    checkOutput("reportTotalHold", obsRepTotal, expRep.totalCycles);
    if (obsRepValid === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("sbUnexpectedReport", 64'd1, 64'd0);
      end else begin
        r = sbQ.pop_front();
        nReports++;
        checkOutput("sbCommits", obsRepCommits, r.commits);
        checkOutput("sbWinCycles", obsRepWin, r.winCycles);
        checkOutput("sbTotalCycles", obsRepTotal, r.totalCycles);
      end
    end
  endtask

  // Called at a falling edge: check what the last rising edge produced,
  // drive the next inputs, advance the model, wait for the next falling edge.
  task automatic applyStimulus(input logic [1:0] c, input logic h,
                               input logic e);
    checkAll();
    cv   = c;
    halt = h;
    err  = e;
    modelStep(c, h, e);
    @(negedge clk);
  endtask

  task automatic doReset(input bit useSmall);
    rstBig   = 1'b0;
    rstSmall = 1'b0;
    sel      = useSmall;
    cv       = 2'b00;
    halt     = 1'b0;
    err      = 1'b0;
    modelReset();
    nReports = 0;
    @(negedge clk);
    checkAll();
    @(negedge clk);
    if (useSmall) rstSmall = 1'b1;
    else          rstBig   = 1'b1;
  endtask

  initial begin
    $display("[TB] start");

    // Reset state and two full windows on the big instance.
    doReset(1'b0);
    for (int i = 1; i <= 1000; i++) applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("win1Valid", 64'(obsRepValid), 64'd1);
    checkOutput("win1Commits", obsRepCommits, 64'd1000);
    checkOutput("win1WinCycles", obsRepWin, 64'd1000);
    checkOutput("win1TotalCycles", obsRepTotal, 64'd1000);
    for (int i = 1001; i <= 2000; i++) applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("win2Commits", obsRepCommits, 64'd2000);
    checkOutput("win2WinCycles", obsRepWin, 64'd1000);
    checkOutput("win2TotalCycles", obsRepTotal, 64'd2000);
    applyStimulus(2'b10, 1'b0, 1'b0);
    checkAll();
    checkOutput("winReportCount", 64'(nReports), 64'd2);

    // Error and halt together: error wins, terminating commit is counted.
    doReset(1'b0);
    for (int i = 1; i <= 49; i++) applyStimulus(2'b01, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b1, 1'b1);
    checkOutput("simulStatus", 64'(obsStatus), 64'd2);
    checkOutput("simulDone", 64'(obsDone), 64'd1);
    checkOutput("simulCommits", obsCommits, 64'd50);
    checkOutput("simulCycles", obsCycles, 64'd50);
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("simulFrozenCycles", obsCycles, 64'd50);
    checkOutput("simulFrozenCommits", obsCommits, 64'd50);

    // Overshoot carry on the small instance.
    doReset(1'b1);
    for (int c = 1; c <= 7; c++) begin
      applyStimulus(2'b11, 1'b0, 1'b0);
      case (c)
        2: checkOutput("ovsC2", obsRepCommits, 64'd4);
        3: checkOutput("ovsC3", obsRepCommits, 64'd6);
        5: checkOutput("ovsC5", obsRepCommits, 64'd10);
        6: checkOutput("ovsC6", obsRepCommits, 64'd12);
        default: checkOutput("ovsNoReport", 64'(obsRepValid), 64'd0);
      endcase
    end
    checkAll();
    checkOutput("ovsReportCount", 64'(nReports), 64'd4);

    // Timeout, then a late halt pulse that must be ignored.
    doReset(1'b1);
    for (int i = 1; i <= 20; i++) applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("toStatus", 64'(obsStatus), 64'd3);
    checkOutput("toCycles", obsCycles, 64'd20);
    applyStimulus(2'b11, 1'b1, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b0);
    checkAll();
    checkOutput("toAfterHaltStatus", 64'(obsStatus), 64'd3);
    checkOutput("toAfterHaltCycles", obsCycles, 64'd20);

    // Asynchronous reset mid-cycle while in TIMEOUT.
    #2;
    rstSmall = 1'b0;
    #1;
    modelReset();
    checkOutput("arstDone", 64'(obsDone), 64'd0);
    checkOutput("arstStatus", 64'(obsStatus), 64'd0);
    checkOutput("arstCycles", obsCycles, 64'd0);
    checkOutput("arstCommits", obsCommits, 64'd0);
    checkOutput("arstRepTotal", obsRepTotal, 64'd0);
    checkOutput("arstRepValid", 64'(obsRepValid), 64'd0);
    @(negedge clk);

    // Stall: commits stop after cycle 10.
    doReset(1'b1);
    for (int i = 1; i <= 10; i++) applyStimulus(2'b11, 1'b0, 1'b0);
    for (int i = 11; i <= 19; i++) applyStimulus(2'b00, 1'b0, 1'b0);
    checkAll();
`ifdef COMMIT_MON_STALL_EN
    checkOutput("stallStatus", 64'(obsStatus), 64'd4);
    checkOutput("stallCycles", obsCycles, 64'd18);
`else
    checkOutput("noStallStatus", 64'(obsStatus), 64'd0);
    checkOutput("noStallCycles", obsCycles, 64'd19);
`endif

    checkOutput("sbDrained", 64'(sbQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/commit_progress_monitor.md
# commit_progress_monitor

Synthesizable commit-progress and run-termination monitor for the core simulation and emulation top. It observes an N-wide retire bus plus halt/error indications, and keeps cumulative commit and cycle counters. Every WINDOW commits it emits a one-cycle report carrying window and cumulative IPC data. It arbitrates the run outcome among halt, error, global timeout and no-commit stall into a sticky terminal status that the bench or an FPGA host polls.

## Interface
- NUM_CHANNELS, 2 — retire channels per cycle (1..8)
- CNT_W, 64 — width of commit and cycle counters
- WINDOW, 1000 — commits per progress report; must be >= NUM_CHANNELS
- TIMEOUT_CYCLES, 100000000 — run cycles before timeout termination; 0 disables
- STALL_LIMIT, 100000 — consecutive commit-free cycles before stall termination
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- commit_valid  in  NUM_CHANNELS  per-channel retire strobe; any bit pattern legal
- halt_in  in  1  program-requested halt, sampled each cycle
- error_in  in  1  checker error, sampled each cycle
- report_valid  out  1  one-cycle pulse: window boundary crossed
- report_commits  out  CNT_W  cumulative commits at the report
- report_win_cycles  out  CNT_W  cycles since the previous report, inclusive
- report_total_cycles  out  CNT_W  cumulative run cycles at the report
- total_commits  out  CNT_W  live cumulative commit count
- total_cycles  out  CNT_W  live cumulative run-cycle count
- done  out  1  sticky; run has terminated
- status  out  3  0 RUN, 1 HALT, 2 ERROR, 3 TIMEOUT, 4 STALL

## Operation
- FSM: RUN, then exactly one terminal state: HALT, ERROR, TIMEOUT or STALL. Terminal states are absorbing until rst_n is asserted.
- In RUN, on each clk edge:
  - pc = popcount(commit_valid), width clog2(NUM_CHANNELS+1).
  - total_commits += pc.
  - total_cycles += 1.
  - win_cyc += 1.
- Window remainder counter win_cnt (clog2(WINDOW) bits):
  - If win_cnt + pc >= WINDOW, a crossing occurs and win_cnt <= win_cnt + pc - WINDOW. Overshoot is carried, so there is no drift.
  - Otherwise win_cnt += pc.
  - WINDOW >= NUM_CHANNELS means at most one crossing per cycle.
- On a crossing, the registered outputs are:
  - report_valid = 1
  - report_commits = new total_commits
  - report_win_cycles = win_cyc + 1
  - report_total_cycles = new total_cycles
  - win_cyc resets to 0.
- Termination conditions, evaluated on the same cycle's inputs and pre-update counters:
  - ERROR: error_in = 1.
  - HALT: halt_in = 1.
  - TIMEOUT: TIMEOUT_CYCLES != 0 and total_cycles + 1 == TIMEOUT_CYCLES.
  - STALL: stall_cnt + 1 == STALL_LIMIT while pc == 0. stall_cnt clears on any pc != 0.
- Priority on simultaneous events: ERROR > HALT > TIMEOUT > STALL.
- Terminating cycle: its commits are counted, cycle counters increment, and a crossing in that cycle still emits its report.
- Terminal states: all counters freeze, report_valid = 0, and inputs are ignored.
- Counter saturation is not required. Wrap-around at 2^CNT_W is modular.

## Timing
- Reset (rst_n low, asynchronous): all counters 0, all report_* 0, report_valid 0, done 0, status 0 (RUN).
- Deassertion of rst_n is synchronised externally. The first edge with rst_n high is run cycle 1.
- Latency: report_valid and the report_* outputs are registered one cycle after the crossing commit is sampled. report_* hold their values until the next report.
- done and status update on the edge that samples the terminating condition, so they are visible one cycle later. done never deasserts except by reset.
- Mid-run reset aborts immediately. Any pending report is lost.

## Configuration
- COMMIT_MON_STALL_EN defined: the stall_cnt counter and the STALL termination are compiled in.
- Undefined: no stall counter exists, status value 4 is never produced, and STALL_LIMIT is ignored.

## Test plan
- **Window report:** NUM_CHANNELS=2, WINDOW=1000; commit_valid=2'b01 every cycle from run cycle 1. Required: report_valid pulses once, with report_commits=1000, report_win_cycles=1000, report_total_cycles=1000. The second report gives 2000/1000/2000.
- **Overshoot carry:** WINDOW=3, commit_valid=2'b11 every cycle. Required: reports after cycles 2, 3, 5, 6, … with report_commits = 4, 6, 10, 12. No cumulative drift.
- **Simultaneous termination:** error_in and halt_in both high on cycle 50 with 1 commit. Required: status=2, done=1, total_commits includes that commit, total_cycles=50, and the counters are frozen afterwards.
- **Timeout:** TIMEOUT_CYCLES=20, no halt. Required: status=3 and total_cycles=20. A later halt_in pulse has no effect.
- **Stall (macro defined):** STALL_LIMIT=8; commits stop after cycle 10. Required: status=4 with total_cycles=18. With the macro undefined, status stays 0.
- **Async reset:** assert rst_n low mid-cycle while in the TIMEOUT state. Required: immediately done=0, status=0, and all outputs are 0 before the next clk edge.
